// File: rtl/rr_arbiter_4_pkg.sv
// Shared definitions for the 4-way round-robin arbiter.
// State encoding and requester/index sizing.
package rr_arbiter_4_pkg;

    localparam int N_REQ = 4;
    localparam int IDX_W = 2;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

endpackage

// File: rtl/Encoder_4x2.sv
// One-hot to binary encoder for the registered grant vector.
// A zero input encodes to index 0.
module Encoder_4x2 (
    input  logic [3:0] D,
    output logic [1:0] B
);

    // Map the single set bit to its binary position
    always_comb begin
        B = 2'd0;
        unique case (1'b1)
            D[0]:    B = 2'd0;
            D[1]:    B = 2'd1;
            D[2]:    B = 2'd2;
            D[3]:    B = 2'd3;
            default: B = 2'd0;
        endcase
    end

endmodule

// File: rtl/rr_arbiter_4.sv
// Round-robin arbiter for four requesters with a registered one-hot grant.
// Grants are held until done, request drop, or the hold limit.
module rr_arbiter_4
    import rr_arbiter_4_pkg::*;
#(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid,
    output logic             timeout
);

    state_e             state_q, state_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   last_q, last_d;
    logic               timeout_q, timeout_d;

    logic               pick_found;
    logic [IDX_W-1:0]   pick_idx;
    logic               hold_lim;
    logic               held;
    logic               release_g;

    // Binary index is always derived from the registered one-hot grant
    Encoder_4x2 u_enc (
        .D (gnt_q),
        .B (gnt_idx)
    );

    // Rotating-priority pick: scan upward from the last winner, wrapping
    always_comb begin
        logic [IDX_W-1:0] cand;
        cand       = '0;
        pick_found = 1'b0;
        pick_idx   = last_q;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = last_q + IDX_W'(k);
            if (!pick_found && req[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    assign hold_lim  = (cnt_q == CNT_W'(MAX_HOLD - 1));
    assign held      = req[gnt_idx];
    assign release_g = done | ~held | hold_lim;

    // Next-state and registered-output logic
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        cnt_d     = cnt_q;
        last_d    = last_q;
        timeout_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                gnt_d = '0;
                cnt_d = '0;
                if (pick_found) begin
                    state_d = ST_GRANT;
                    gnt_d   = N_REQ'(1) << pick_idx;
                    last_d  = pick_idx;
                end
            end
            ST_GRANT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (release_g) begin
                    state_d   = ST_IDLE;
                    gnt_d     = '0;
                    cnt_d     = '0;
                    timeout_d = hold_lim & ~done & held;
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
                cnt_d   = '0;
            end
        endcase
    end

    // State register; last winner resets to 3 so requester 0 wins first
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            gnt_q     <= '0;
            cnt_q     <= '0;
            last_q    <= IDX_W'(N_REQ - 1);
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            cnt_q     <= cnt_d;
            last_q    <= last_d;
            timeout_q <= timeout_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_valid = |gnt_q;
    assign timeout   = timeout_q;

endmodule
